// File: rtl/edge_delay_meter.sv
// Edge-to-edge delay meter.
// Measures, in clk cycles, the time from a rising edge on SignalIn to the next
// rising edge on SignalOut. Both inputs are asynchronous. Each one passes through
// an identical synchronizer and edge detector, so their latencies cancel out.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for Arm or Continuous
// ARMED    | waiting for a start edge (synchronized SignalIn rise)
// COUNTING | counting cycles until a stop edge or TIMEOUT
// DONE     | one-cycle result slot, then re-arm (Continuous) or idle
module edge_delay_meter #(
   parameter int COUNT_WIDTH = 8,
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   SignalIn,
   input  logic                   SignalOut,
   input  logic                   Arm,
   input  logic                   Continuous,
   output logic                   Busy,
   output logic [COUNT_WIDTH-1:0] DelayCount,
   output logic                   Valid,
   output logic                   Timeout
);

   typedef enum logic [1:0] {IDLE, ARMED, COUNTING, DONE} state_t;

   localparam logic [COUNT_WIDTH:0] TIMEOUT_W = (COUNT_WIDTH+1)'(TIMEOUT);

   logic [SYNC_STAGES-1:0] in_sync_q;
   logic [SYNC_STAGES-1:0] out_sync_q;
   logic                   in_prev_q;
   logic                   out_prev_q;
   // prime_q[k] is set once stage k holds a real post-reset sample. The last bit
   // covers the prev flop, so a level that is already high at reset release does
   // not look like a rising edge.
   logic [SYNC_STAGES:0]   prime_q;
   logic                   start_edge;
   logic                   stop_edge;

   state_t                 state_q;
   logic [COUNT_WIDTH-1:0] cnt_q;
   logic [COUNT_WIDTH:0]   cnt_inc;

   // Synchronizer chains, previous-value flops for edge detection, and priming
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_sync_q  <= '0;
         out_sync_q <= '0;
         in_prev_q  <= 1'b0;
         out_prev_q <= 1'b0;
         prime_q    <= '0;
      end else begin
         in_sync_q  <= {in_sync_q[SYNC_STAGES-2:0], SignalIn};
         out_sync_q <= {out_sync_q[SYNC_STAGES-2:0], SignalOut};
         in_prev_q  <= in_sync_q[SYNC_STAGES-1];
         out_prev_q <= out_sync_q[SYNC_STAGES-1];
         prime_q    <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign start_edge = in_sync_q[SYNC_STAGES-1]  & ~in_prev_q  & prime_q[SYNC_STAGES];
   assign stop_edge  = out_sync_q[SYNC_STAGES-1] & ~out_prev_q & prime_q[SYNC_STAGES];

   // The extra bit keeps the TIMEOUT compare exact when TIMEOUT is the counter's maximum value
   assign cnt_inc = {1'b0, cnt_q} + 1'b1;

   // Measurement FSM with registered Busy/Valid/Timeout/DelayCount
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         DelayCount <= '0;
         Valid      <= 1'b0;
         Timeout    <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         Valid   <= 1'b0;
         Timeout <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Arm || Continuous) begin
                  state_q <= ARMED;
                  Busy    <= 1'b1;
               end
            end
            ARMED: begin
               if (start_edge) begin
                  cnt_q <= '0;
                  if (stop_edge) begin
                     DelayCount <= '0;
                     Valid      <= 1'b1;
                     Busy       <= 1'b0;
                     state_q    <= DONE;
                  end else begin
                     state_q    <= COUNTING;
                  end
               end
            end
            COUNTING: begin
               cnt_q <= cnt_inc[COUNT_WIDTH-1:0];
               if (stop_edge) begin
                  DelayCount <= cnt_inc[COUNT_WIDTH-1:0];
                  Valid      <= 1'b1;
                  Busy       <= 1'b0;
                  state_q    <= DONE;
               end else if (cnt_inc == TIMEOUT_W) begin
                  Timeout    <= 1'b1;
                  Busy       <= 1'b0;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (Continuous) begin
                  state_q <= ARMED;
                  Busy    <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_edge_delay_meter.sv
// Testbench for edge_delay_meter. Inputs change on the falling edge, so an
// input change made d cycles after another is sampled exactly d rising edges
// later. The reference model predicts the outcome directly from the delay:
//   d <= TIMEOUT : Valid with DelayCount = d, which rises d+SYNC+1 edges after SignalIn is first sampled
//   d >  TIMEOUT : Timeout at the TIMEOUT+SYNC+1 position, and DelayCount keeps its previous value
module tb_edge_delay_meter;

   localparam int CW   = 8;
   localparam int TO   = 10;
   localparam int SYNC = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          SignalIn;
   logic          SignalOut;
   logic          Arm;
   logic          Continuous;
   logic          Busy;
   logic [CW-1:0] DelayCount;
   logic          Valid;
   logic          Timeout;

   int n_cmp  = 0;
   int n_fail = 0;
   int vcnt   = 0;
   int tcnt   = 0;
   int bcnt   = 0;
   int model_dc = 0;

   edge_delay_meter #(.COUNT_WIDTH(CW), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .SignalIn   (SignalIn),
      .SignalOut  (SignalOut),
      .Arm        (Arm),
      .Continuous (Continuous),
      .Busy       (Busy),
      .DelayCount (DelayCount),
      .Valid      (Valid),
      .Timeout    (Timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Valid)            vcnt++;
      if (Timeout)          tcnt++;
      if (Valid && Timeout) bcnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_arm();
      @(negedge clk); Arm = 1'b1;
      @(negedge clk); Arm = 1'b0;
   endtask

   task automatic lower_inputs();
      @(negedge clk);
      SignalIn  = 1'b0;
      SignalOut = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // One measurement: SignalIn rises, SignalOut rises d cycles later (never if d >= 40)
   task automatic run_meas(input int d, input bit do_arm, input string tag);
      int  v0, t0, got_at;
      bit  exp_valid, got_v, got_t;
      int  exp_at;
      v0 = vcnt; t0 = tcnt;
      got_at = -1; got_v = 1'b0; got_t = 1'b0;
      if (do_arm) pulse_arm();
      check($sformatf("%s_busy_armed", tag), Busy, 1);
      exp_valid = (d <= TO);
      exp_at    = (exp_valid ? d : TO) + SYNC;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) SignalIn  = 1'b1;
         if (i == d) SignalOut = 1'b1;
         @(posedge clk); #1;
         if (Valid || Timeout) begin
            got_at = i; got_v = Valid; got_t = Timeout;
            break;
         end
      end
      if (exp_valid) model_dc = d;
      check($sformatf("%s_latency", tag), got_at, exp_at);
      check($sformatf("%s_valid", tag), got_v, exp_valid);
      check($sformatf("%s_timeout", tag), got_t, !exp_valid);
      check($sformatf("%s_dc", tag), DelayCount, model_dc);
      @(posedge clk); #1;
      check($sformatf("%s_pulse_len", tag), Valid | Timeout, 0);
      check($sformatf("%s_busy_after", tag), Busy, 0);
      check($sformatf("%s_nvalid", tag), vcnt - v0, exp_valid ? 1 : 0);
      check($sformatf("%s_ntimeout", tag), tcnt - t0, exp_valid ? 0 : 1);
      lower_inputs();
   endtask

   initial begin
      int v0, t0, nv;
      rst = 1'b1; SignalIn = 1'b0; SignalOut = 1'b0; Arm = 1'b0; Continuous = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {Busy, Valid, Timeout, DelayCount}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_no_arm", Busy, 0);

      run_meas(0,  1'b1, "same_edge");
      run_meas(5,  1'b1, "delay5");
      run_meas(99, 1'b1, "timeout");
      run_meas(TO, 1'b1, "stop_at_timeout");
      run_meas(TO + 1, 1'b1, "one_past_timeout");

      // A stop edge while ARMED without a start edge must be ignored
      pulse_arm();
      v0 = vcnt; t0 = tcnt;
      @(negedge clk); SignalOut = 1'b1;
      repeat (8) @(negedge clk);
      check("early_stop_busy", Busy, 1);
      check("early_stop_nores", (vcnt - v0) + (tcnt - t0), 0);
      lower_inputs();
      run_meas(4, 1'b0, "after_early_stop");

      // Continuous mode: 200-cycle square wave, delayed copy 7 cycles later
      @(negedge clk); Continuous = 1'b1;
      t0 = tcnt; nv = 0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         SignalIn  = ((t % 200) < 100);
         SignalOut = (t >= 7) && (((t - 7) % 200) < 100);
         @(posedge clk); #1;
         if (Valid) begin
            nv++;
            check($sformatf("cont_dc_%0d", nv), DelayCount, 7);
         end
      end
      check("cont_nvalid", nv, 3);
      check("cont_ntimeout", tcnt - t0, 0);
      @(negedge clk); Continuous = 1'b0;
      model_dc = 7;
      lower_inputs();
      // Arm is ignored because the block is still ARMED, and the measurement runs anyway.
      run_meas(2, 1'b1, "after_cont");

      for (int k = 0; k < 8; k++) begin
         int d;
         d = $urandom_range(0, TO + 3);
         run_meas(d, 1'b1, $sformatf("rand%0d_d%0d", k, d));
      end

      // Reset while COUNTING at count 3
      pulse_arm();
      v0 = vcnt; t0 = tcnt;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) SignalIn = 1'b1;
         @(posedge clk);
      end
      #1 rst = 1'b1;
      #1 check("midrst_outputs", {Busy, Valid, Timeout, DelayCount}, 0);
      model_dc = 0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); SignalOut = 1'b1;
      repeat (20) @(negedge clk);
      check("midrst_nores", (vcnt - v0) + (tcnt - t0), 0);
      check("midrst_idle", Busy, 0);
      lower_inputs();
      run_meas(3, 1'b1, "after_midrst");

      // Inputs already high at reset release: no edge may be detected
      @(negedge clk); SignalIn = 1'b1; SignalOut = 1'b1; rst = 1'b1;
      @(negedge clk); rst = 1'b0; Arm = 1'b1;
      @(negedge clk); Arm = 1'b0;
      v0 = vcnt; t0 = tcnt;
      repeat (12) @(negedge clk);
      check("hi_at_release_armed", Busy, 1);
      check("hi_at_release_nores", (vcnt - v0) + (tcnt - t0), 0);
      model_dc = 0;
      lower_inputs();
      run_meas(6, 1'b0, "after_hi_release");

      check("never_both", bcnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/edge_delay_meter.md
EDGE_DELAY_METER -- requirements
Module: edge_delay_meter

Parameters
REQ-001 SHALL provide parameter COUNT_WIDTH, default 8, the width of the measured-delay result.
REQ-002 SHALL provide parameter TIMEOUT, default 255, the maximum count before a measurement is abandoned; legal range 1 to 2^COUNT_WIDTH-1.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, the synchronizer depth per input; legal range >= 2.

Interface
REQ-004 SHALL have clk, input, 1, the single clock for all logic.
REQ-005 SHALL have rst, input, 1, a reset that is asynchronous and active-high.
REQ-006 SHALL have SignalIn, input, 1, the asynchronous reference signal, i.e. the delay-line input.
REQ-007 SHALL have SignalOut, input, 1, the asynchronous delayed signal, i.e. the delay-line output.
REQ-008 SHALL have Arm, input, 1, a request to start one measurement, sampled high on a clk edge.
REQ-009 SHALL have Continuous, input, 1, which when high makes the block re-arm automatically after each result.
REQ-010 SHALL have Busy, output, 1, high in states ARMED and COUNTING.
REQ-011 SHALL have DelayCount, output, COUNT_WIDTH, the last valid delay in clk cycles.
REQ-012 SHALL have Valid, output, 1, a one-cycle pulse marking that DelayCount has been updated.
REQ-013 SHALL have Timeout, output, 1, a one-cycle pulse marking an abandoned measurement.

Function
REQ-014 SignalIn and SignalOut SHALL each pass through an identical SYNC_STAGES flip-flop synchronizer followed by a registered rising-edge detector, giving equal latency on both paths.
REQ-015 The FSM SHALL have four states: IDLE, ARMED, COUNTING and DONE.
REQ-016 IDLE -> ARMED SHALL occur when Arm=1 or Continuous=1; otherwise the FSM SHALL stay in IDLE.
REQ-017 ARMED -> COUNTING SHALL occur on a start edge (synchronized SignalIn rise), loading the counter with 0.
REQ-018 A stop edge in ARMED without a simultaneous start edge SHALL be ignored.
REQ-019 A start edge and a stop edge detected in the same cycle in ARMED SHALL go to DONE, load DelayCount=0 and pulse Valid.
REQ-020 COUNTING SHALL increment the counter by 1 every clk cycle.
REQ-021 A stop edge in COUNTING SHALL load DelayCount = counter + 1 (cycles between start and stop detection), pulse Valid and go to DONE.
REQ-022 In COUNTING, if counter+1 reaches TIMEOUT with no stop edge in that cycle, the block SHALL pulse Timeout, leave DelayCount unchanged and go to DONE.
REQ-023 A stop edge in the same cycle that counter+1 reaches TIMEOUT SHALL take priority: DelayCount=TIMEOUT, Valid pulse, no Timeout.
REQ-024 Start edges received in COUNTING SHALL be ignored; the first start edge defines the measurement.
REQ-025 DONE SHALL last exactly one cycle, then go to ARMED if Continuous=1, otherwise to IDLE.
REQ-026 Arm asserted while Busy or in DONE SHALL be ignored, with no queuing.
REQ-027 Valid and Timeout SHALL be registered, never high together, and high for exactly one cycle per result.
REQ-028 DelayCount SHALL hold its value between Valid pulses.
REQ-029 Valid SHALL rise SYNC_STAGES+1 clk edges after the first edge that samples SignalOut high, counting that edge as the first.

Reset
REQ-030 rst=1 SHALL asynchronously force the FSM to IDLE, clear all synchronizer and edge-detector flops and the counter, and set DelayCount=0, Valid=0, Timeout=0 and Busy=0.
REQ-031 rst asserted mid-measurement SHALL abort the measurement without a Valid or Timeout pulse.
REQ-032 After rst deasserts, the first measurement SHALL require a fresh Arm, or Continuous=1.
REQ-033 An input that is already high at reset release SHALL NOT be detected as a rising edge.

Verification
REQ-034 Bench SHALL check: Arm pulse, then SignalIn rises, then SignalOut rises 5 cycles later -> DelayCount=5, one Valid pulse, Busy=0 afterwards.
REQ-035 Bench SHALL check: SignalIn and SignalOut rise on the same clk edge -> DelayCount=0 with Valid.
REQ-036 Bench SHALL check: TIMEOUT=10, SignalIn rises, SignalOut stays low -> Timeout pulse 10 cycles after start detection and DelayCount keeps its previous value.
REQ-037 Bench SHALL check: Continuous=1 with a 200-cycle period square wave on SignalIn and SignalOut delayed 7 cycles -> a Valid pulse every period, each with DelayCount=7.
REQ-038 Bench SHALL check: rst pulsed while COUNTING at count 3 -> all outputs 0 immediately, no Valid or Timeout, and IDLE retained until the next Arm.
REQ-039 Bench SHALL check: SignalOut rises before SignalIn while ARMED -> that edge is ignored, and a later SignalIn/SignalOut pair with a 4-cycle delay yields DelayCount=4.
